// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared state encoding and default sizing for the tick timer
package tick_timer_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_PERIOD = 5;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/tick_timer_if.sv
// tick_timer_if: config handshake, commands and timer outputs
interface tick_timer_if import tick_timer_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_oneshot;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             toggle;
    logic             busy;
    logic             done;
    modport master (
        output cfg_valid, cfg_period, cfg_oneshot, start, stop,
        input  cfg_ready, count, tick, toggle, busy, done
    );
    modport slave (
        input  cfg_valid, cfg_period, cfg_oneshot, start, stop,
        output cfg_ready, count, tick, toggle, busy, done
    );
endinterface

// File: rtl/tick_timer_ctrl_period_counter.sv
// period_counter: counts 0..period-1 while enabled and flags the wrap edge
module period_counter import tick_timer_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);
    // period is pre-clamped to >=1, so period-1 never underflows
    assign wrap = en && (count == period - WIDTH'(1));
    // count advances while enabled, returns to zero on wrap or clear
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (en) count <= wrap ? '0 : count + WIDTH'(1);
    end
endmodule

// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: run-control FSM turning a period counter into tick/toggle events
module tick_timer_ctrl import tick_timer_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEFAULT_PERIOD = DEF_PERIOD
) (
    input logic        clk,
    input logic        rst,
    tick_timer_if.slave bus
);
    localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(DEFAULT_PERIOD);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_c, count;
    logic             oneshot_q, tick_q, toggle_q, done_q;
    logic             cfg_ready, cfg_fire, en, wrap, busy;
    assign period_c = (bus.cfg_period == '0) ? WIDTH'(1) : bus.cfg_period;
    assign cfg_fire = bus.cfg_valid && cfg_ready;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    // next-state: stop always dominates start; a one-shot wrap parks in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = (bus.start && !bus.stop) ? RUN : IDLE;
            RUN:  state_d = bus.stop ? IDLE : (wrap && oneshot_q) ? DONE : RUN;
            DONE: state_d = (bus.start && !bus.stop) ? RUN :
                            (cfg_fire || bus.start) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // state-decoded outputs; a stop in RUN freezes the counter so it cannot wrap
    always_comb begin
        busy      = state_q == RUN;
        cfg_ready = state_q != RUN;
        en        = busy && !bus.stop;
    end
    period_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (!en),
        .en     (en),
        .period (period_q),
        .count  (count),
        .wrap   (wrap)
    );
    // config latch and tick/toggle/done bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q  <= RST_PERIOD;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            toggle_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q   <= wrap;
            toggle_q <= toggle_q ^ wrap;
            if (cfg_fire) begin
                period_q  <= period_c;
                oneshot_q <= bus.cfg_oneshot;
            end
            if (wrap && oneshot_q) done_q <= 1'b1;
            else if (cfg_fire || (state_d == RUN && state_q != RUN)) done_q <= 1'b0;
        end
    end
    assign bus.cfg_ready = cfg_ready;
    assign bus.count     = count;
    assign bus.tick      = tick_q;
    assign bus.toggle    = toggle_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_tick_timer_ctrl.sv
// tb_tick_timer_ctrl: directed checks of the tick timer controller
module tb_tick_timer_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_tog = 1'b0;
    tick_timer_if #(.WIDTH(32)) bus ();
    tick_timer_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic cfg(input logic [31:0] p, input logic os);
        bus.cfg_valid   = 1'b1;
        bus.cfg_period  = p;
        bus.cfg_oneshot = os;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, bus.count, 0);
        chk({tag, "_tick"}, bus.tick, 0);
        chk({tag, "_toggle"}, bus.toggle, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ready"}, bus.cfg_ready, 1);
    endtask
    // n cycles of periodic run with period p, starting just after RUN entry
    task automatic run(input string tag, input int p, input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            if (k % p == 0) exp_tog = ~exp_tog;
            chk({tag, "_count"}, bus.count, k % p);
            chk({tag, "_tick"}, bus.tick, (k % p == 0) ? 1 : 0);
            chk({tag, "_toggle"}, bus.toggle, exp_tog);
            chk({tag, "_busy"}, bus.busy, 1);
        end
    endtask
    initial begin
        bus.cfg_valid = 0; bus.cfg_period = 0; bus.cfg_oneshot = 0;
        bus.start = 0; bus.stop = 0;
        step(); step();
        rst = 1'b0;
        chk_reset("rst");
        // periodic at default period 5
        bus.start = 1; step(); bus.start = 0;
        chk("p5_entry_busy", bus.busy, 1);
        chk("p5_entry_count", bus.count, 0);
        run("p5", 5, 15);
        bus.stop = 1; step(); bus.stop = 0;
        chk("p5_stop_busy", bus.busy, 0);
        chk("p5_stop_toggle", bus.toggle, 1);
        // one-shot P=3 with same-cycle start
        cfg(3, 1); bus.start = 1; step(); bus.cfg_valid = 0; bus.start = 0;
        chk("os_entry_busy", bus.busy, 1);
        step(); chk("os_c1", bus.count, 1); chk("os_t1", bus.tick, 0);
        step(); chk("os_c2", bus.count, 2); chk("os_t2", bus.tick, 0);
        step();
        chk("os_tick", bus.tick, 1);
        chk("os_done", bus.done, 1);
        chk("os_busy", bus.busy, 0);
        chk("os_count", bus.count, 0);
        chk("os_toggle", bus.toggle, 0);
        exp_tog = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            chk("os_quiet_tick", bus.tick, 0);
        end
        chk("os_done_sticky", bus.done, 1);
        // P=0 clamps to 1: cfg transfer from DONE goes to IDLE and clears done
        cfg(0, 0); step(); bus.cfg_valid = 0;
        chk("p0_cfg_done", bus.done, 0);
        chk("p0_cfg_ready", bus.cfg_ready, 1);
        bus.start = 1; step(); bus.start = 0;
        run("p1", 1, 4);
        bus.stop = 1; step(); bus.stop = 0;
        chk("p1_stop_tick", bus.tick, 0);
        chk("p1_stop_toggle", bus.toggle, exp_tog);
        // P=4, stop lands exactly on the wrap edge
        cfg(4, 0); step(); bus.cfg_valid = 0;
        bus.start = 1; step(); bus.start = 0;
        run("p4", 4, 3);
        bus.stop = 1; step(); bus.stop = 0;
        chk("p4_stopwrap_tick", bus.tick, 0);
        chk("p4_stopwrap_toggle", bus.toggle, exp_tog);
        chk("p4_stopwrap_busy", bus.busy, 0);
        chk("p4_stopwrap_count", bus.count, 0);
        // cfg held pending through RUN
        bus.start = 1; step(); bus.start = 0;
        cfg(7, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("hold_ready", bus.cfg_ready, 0);
            chk("hold_tick", bus.tick, (k == 4) ? 1 : 0);
        end
        exp_tog = ~exp_tog;
        bus.stop = 1; step(); bus.stop = 0;
        chk("hold_stop_ready", bus.cfg_ready, 1);
        step(); bus.cfg_valid = 0;
        bus.start = 1; step(); bus.start = 0;
        run("p7", 7, 14);
        bus.stop = 1; step(); bus.stop = 0;
        // reset mid-run with P=9
        cfg(9, 0); step(); bus.cfg_valid = 0;
        bus.start = 1; step(); bus.start = 0;
        run("p9", 9, 2);
        rst = 1; step(); rst = 0;
        chk_reset("midrst");
        exp_tog = 1'b0;
        bus.start = 1; step(); bus.start = 0;
        run("post", 5, 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
